// File: rtl/sr_pulse_encoder.sv
// sr_pulse_encoder: turns two raw bouncy pushbuttons into clean, mutually
// exclusive S/R command pulses for a downstream SR flip-flop.
//
// Optional feature macro: SR_SKIP_REDUNDANT_EN
//   defined   -> requests that would not change q_model are dropped in IDLE
//   undefined -> every accepted request produces a pulse
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronised cycles before a debounced level flips (>=2)
//   PULSE_CYCLES     width of each S/R pulse in cycles (>=1)
//   GAP_CYCLES       idle cycles after each pulse (>=1)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   set_btn    raw set pushbutton (asynchronous, bouncy)
//   reset_btn  raw reset pushbutton (asynchronous, bouncy)
//   S, R       registered set / reset commands, never high together
//   q_model    level the flip-flop holds after the last completed pulse
//   busy       high whenever the FSM is outside IDLE
//   conflict   one-cycle pulse when simultaneous requests are discarded
module sr_pulse_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PULSE_CYCLES    = 1,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic reset_btn,
  output logic S,
  output logic R,
  output logic q_model,
  output logic busy,
  output logic conflict
);

  localparam int unsigned CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned MAX_PHASE = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned PHASE_W   = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
  localparam int unsigned NCH       = 2;

  localparam logic [CNT_W-1:0]   DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PULSE_LOAD = PHASE_W'(PULSE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] GAP_LOAD   = PHASE_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  // Channel 0 is set, channel 1 is reset.
  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] deb;
  logic [NCH-1:0] deb_d;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] pend_clr;
  logic [CNT_W-1:0] db_cnt [NCH];

  state_t               state, state_n;
  logic [PHASE_W-1:0]   phase, phase_n;
  logic                 q_n;
  logic                 conflict_c;

  assign raw  = {reset_btn, set_btn};
  assign rise = deb & ~deb_d;

  // Synchronise and debounce both channels; the level flips only after
  // DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= ~deb[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CNT_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Pending flags: a fresh press wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~pend_clr) | rise;
  end

  // FSM state, phase counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      q_model  <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      q_model  <= q_n;
      S        <= (state_n == PULSE_S);
      R        <= (state_n == PULSE_R);
      busy     <= (state_n != IDLE);
      conflict <= conflict_c;
    end
  end

  // Next-state logic; the phase counter is loaded on entry and counts down.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    q_n        = q_model;
    pend_clr   = '0;
    conflict_c = 1'b0;
    case (state)
      IDLE: begin
        if (pend[0] && pend[1]) begin
          pend_clr   = 2'b11;
          conflict_c = 1'b1;
        end else if (pend[0]) begin
          pend_clr[0] = 1'b1;
`ifdef SR_SKIP_REDUNDANT_EN
          if (!q_model) begin
            state_n = PULSE_S;
            phase_n = PULSE_LOAD;
          end
`else
          state_n = PULSE_S;
          phase_n = PULSE_LOAD;
`endif
        end else if (pend[1]) begin
          pend_clr[1] = 1'b1;
`ifdef SR_SKIP_REDUNDANT_EN
          if (q_model) begin
            state_n = PULSE_R;
            phase_n = PULSE_LOAD;
          end
`else
          state_n = PULSE_R;
          phase_n = PULSE_LOAD;
`endif
        end
      end
      PULSE_S, PULSE_R: begin
        if (phase == '0) begin
          state_n = GAP;
          phase_n = GAP_LOAD;
          q_n     = (state == PULSE_S);
        end else begin
          phase_n = phase - PHASE_W'(1);
        end
      end
      GAP: begin
        if (phase == '0) state_n = IDLE;
        else             phase_n = phase - PHASE_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sr_pulse_encoder.sv
// tb_sr_pulse_encoder: directed bench for sr_pulse_encoder with
// DEBOUNCE_CYCLES=4, PULSE_CYCLES=1, GAP_CYCLES=2. Edge 0 is the first
// rising edge that samples a newly raised button.
module tb_sr_pulse_encoder;

  logic clk;
  logic rst;
  logic set_btn;
  logic reset_btn;
  logic S;
  logic R;
  logic q_model;
  logic busy;
  logic conflict;

  int checks;
  int failures;

`ifdef SR_SKIP_REDUNDANT_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  sr_pulse_encoder #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (1),
    .GAP_CYCLES     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .set_btn  (set_btn),
    .reset_btn(reset_btn),
    .S        (S),
    .R        (R),
    .q_model  (q_model),
    .busy     (busy),
    .conflict (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare all five outputs at one point in time.
  task automatic sample(input string base, input int e, input bit es, input bit er,
                        input bit eq, input bit eb, input bit ec);
    check($sformatf("%s_e%0d_S", base, e),        32'(S),        32'(es));
    check($sformatf("%s_e%0d_R", base, e),        32'(R),        32'(er));
    check($sformatf("%s_e%0d_q", base, e),        32'(q_model),  32'(eq));
    check($sformatf("%s_e%0d_busy", base, e),     32'(busy),     32'(eb));
    check($sformatf("%s_e%0d_conflict", base, e), 32'(conflict), 32'(ec));
  endtask

  // Release both buttons and let debouncers and FSM settle.
  task automatic release_wait();
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    step(12);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    set_btn   = 1'b0;
    reset_btn = 1'b0;

    // Reset state
    step(3);
    sample("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(2);
    sample("post_reset", 0, 0, 0, 0, 0, 0);

    // Clean set press: S at edge 7, q from edge 8, busy edges 7..9
    set_btn = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step(1);
      sample("set", e, e == 7, 0, e >= 8, (e >= 7) && (e <= 9), 0);
    end
    release_wait();

    // Redundant set with q_model=1
    set_btn = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step(1);
      sample("redundant", e, !SKIP && (e == 7), 0, 1, !SKIP && (e >= 7) && (e <= 9), 0);
    end
    release_wait();

    // Bouncy reset: two 3-cycle high glitches produce nothing
    for (int k = 0; k < 2; k++) begin
      reset_btn = 1'b1;
      for (int e = 0; e < 3; e++) begin
        step(1);
        sample("bounce_hi", k * 3 + e, 0, 0, 1, 0, 0);
      end
      reset_btn = 1'b0;
      for (int e = 0; e < 3; e++) begin
        step(1);
        sample("bounce_lo", k * 3 + e, 0, 0, 1, 0, 0);
      end
    end
    reset_btn = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step(1);
      sample("reset_hold", e, 0, e == 7, e < 8, (e >= 7) && (e <= 9), 0);
    end
    release_wait();

    // Simultaneous press: conflict at edge 7, no pulse, q stays 0
    set_btn   = 1'b1;
    reset_btn = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step(1);
      sample("simul", e, 0, 0, 0, 0, e == 7);
    end
    release_wait();

    // Queued: reset pending while S high, R four cycles after S
    set_btn = 1'b1;
    for (int e = 0; e < 16; e++) begin
      step(1);
      sample("queued", e, e == 7, e == 11, (e >= 8) && (e < 12),
             ((e >= 7) && (e <= 9)) || ((e >= 11) && (e <= 13)), 0);
      if (e == 0) reset_btn = 1'b1;
    end
    release_wait();

    // Reset mid-pulse: S drops immediately, no pulse afterwards
    set_btn = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step(1);
      sample("midpulse", e, e == 7, 0, 0, e == 7, 0);
    end
    rst     = 1'b1;
    set_btn = 1'b0;
    #1;
    sample("midpulse_rst", 0, 0, 0, 0, 0, 0);
    step(2);
    rst = 1'b0;
    for (int e = 0; e < 15; e++) begin
      step(1);
      sample("after_rst", e, 0, 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_pulse_encoder.md
# sr_pulse_encoder

Command-side driver for the lab's SR flip-flop. It turns two raw pushbuttons (set, reset) into clean, mutually exclusive S/R command pulses. Each button is synchronised and debounced, and each press is converted into exactly one timed S or R pulse. A model of the level the flip-flop will hold is tracked and exposed. The block sits between board switches and the S/R inputs of the flip-flop, and guarantees the undefined S=R=1 combination is never driven.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed before a debounced level changes (≥2).
- `PULSE_CYCLES`, 1: width of each S or R pulse in clock cycles (≥1).
- `GAP_CYCLES`, 2: minimum idle cycles after each pulse before the next pulse (≥1).
- `clk` in 1: single system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `set_btn` in 1: raw set pushbutton, asynchronous and bouncy.
- `reset_btn` in 1: raw reset pushbutton, asynchronous and bouncy.
- `S` out 1: set command to the flip-flop.
- `R` out 1: reset command to the flip-flop.
- `q_model` out 1: level the downstream flip-flop holds after the last completed pulse.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `conflict` out 1: one-cycle pulse when simultaneous set and reset requests are discarded.

## Operation
- **Per channel:**
  - 2-flop synchroniser feeds a debouncer.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - The counter increments on every edge where the synchronised input differs from the debounced level.
  - The counter clears on any edge where they are equal.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
- **Request capture:**
  - A rising edge of a debounced level sets that channel's pending flag on the next edge.
  - Each channel holds one pending flag; further presses while the flag is set are absorbed.
  - Falling edges are ignored.
- **FSM states:** IDLE, PULSE_S, PULSE_R, GAP.
  - IDLE, only set pending: go to PULSE_S and clear set pending.
  - IDLE, only reset pending: go to PULSE_R and clear reset pending.
  - IDLE, both pending: stay in IDLE, clear both flags, assert `conflict` for 1 cycle, drive no pulse.
  - PULSE_S / PULSE_R: hold for PULSE_CYCLES cycles, then go to GAP. On that exit edge, `q_model` becomes 1 (PULSE_S) or 0 (PULSE_R).
  - GAP: hold for GAP_CYCLES cycles, then go to IDLE.
  - Requests arriving during PULSE or GAP are captured and served from IDLE.
- **Output decode:**
  - `S` is high only in PULSE_S; `R` is high only in PULSE_R.
  - `S` and `R` are never high in the same cycle.
  - `S` and `R` are registered (state decode of registered state only).
- **Shared counter:** one phase counter serves PULSE and GAP. It is loaded on state entry and sized for max(PULSE_CYCLES, GAP_CYCLES).

## Timing
- **Reset (async, immediate):**
  - `S`=0, `R`=0, `q_model`=0, `busy`=0, `conflict`=0.
  - Synchronisers, debounced levels, counters and pending flags all 0; FSM in IDLE.
  - Reset asserted mid-pulse drops `S`/`R` in the same cycle, with no `q_model` update.
- **Press latency:** let edge 0 be the first edge sampling a raw high that stays stable.
  - Debounced level rises at edge DEBOUNCE_CYCLES+1.
  - Pending flag sets at edge DEBOUNCE_CYCLES+2.
  - `S`/`R` rises at edge DEBOUNCE_CYCLES+3.
- **Pulse width:** the pulse is exactly PULSE_CYCLES cycles. `busy` rises with the pulse and falls GAP_CYCLES cycles after the pulse ends.
- **Back-to-back pulses:** minimum spacing from pulse start to pulse start is PULSE_CYCLES+GAP_CYCLES+1 cycles, because IDLE occupies one cycle.
- **Bounce:** a glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse.

## Configuration
- `SR_SKIP_REDUNDANT_EN` defined:
  - In IDLE, a set request while `q_model`=1, or a reset request while `q_model`=0, is cleared without a pulse and the FSM stays in IDLE.
  - The conflict rule still takes precedence.
- `SR_SKIP_REDUNDANT_EN` undefined: every accepted request produces a pulse regardless of `q_model`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, PULSE_CYCLES=1, GAP_CYCLES=2.
- **Clean set press:** hold `set_btn`=1 from edge 0 → `S`=1 for exactly edge 7 to edge 8, `q_model`=1 from edge 8, `busy` low from edge 10; `R` stays 0.
- **Bouncy reset press:** toggle `reset_btn` with high periods of 3 cycles, then hold high → single `R` pulse, 7 edges after the stable hold begins; no pulse during the bounce.
- **Simultaneous press:** raise `set_btn` and `reset_btn` on the same edge → `conflict`=1 for 1 cycle at edge 7; `S`=`R`=0 throughout; `q_model` unchanged.
- **Queued requests:** press set, then press reset while `S` is high → R pulse starts 4 cycles after S rose; `q_model` goes 0→1→0.
- **Redundant set, macro defined:** `q_model`=1, press set again → no pulse and `busy` stays 0. With the macro undefined → a 1-cycle `S` pulse.
- **Reset mid-pulse:** assert `rst` while `S`=1 → `S` falls immediately, `q_model`=0, FSM in IDLE, and no pulse after `rst` releases until a new press.
